// File: rtl/mod4051_reduce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mod4051_reduce_ctrl
// Brief    : Reduces a wide operand mod 4051 by streaming 6-bit chunks through
//            a shared chunk-residue LUT bank and accumulating the residues.
//            Optional MOD4051_ZERO_SKIP_EN stops issuing after the top nonzero chunk.
// Revision : 1.0 - initial release
// ============================================================================
module mod4051_reduce_ctrl #(
    parameter int OP_W    = 500,
    parameter int LUT_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_data,
    output logic            lut_req,
    output logic [6:0]      lut_sel,
    output logic [5:0]      lut_x,
    input  logic [11:0]     lut_z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [11:0]     out_data
);

    localparam int          N_CHUNKS = (OP_W + 5) / 6;
    localparam int          PAD_W    = N_CHUNKS * 6;
    localparam logic [6:0]  c_LAST   = 7'(N_CHUNKS - 1);
    localparam logic [12:0] c_MOD    = 13'd4051;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAD_W-1:0] r_data;
    logic [PAD_W-1:0] w_pad;
    logic [6:0]       r_cnt;
    logic [11:0]      r_acc;
    logic [11:0]      w_acc_nxt;
    logic [12:0]      w_sum;
    logic             w_accept;
    logic             w_issue;
    logic             w_due;
    logic             w_pipe_busy;
    logic             w_last;
    logic             w_skip_all;

    assign w_pad    = PAD_W'(in_data);
    assign w_accept = in_valid && in_ready;
    assign w_issue  = lut_req;

    // Residues are already < 4051, so one conditional subtract keeps acc reduced.
    assign w_sum     = {1'b0, r_acc} + {1'b0, lut_z};
    assign w_acc_nxt = (w_sum >= c_MOD) ? 12'(w_sum - c_MOD) : w_sum[11:0];

`ifdef MOD4051_ZERO_SKIP_EN
    logic [6:0] r_top;
    logic [6:0] w_top;

    always_comb begin
        w_top = '0;
        for (int i = 0; i < N_CHUNKS; i++) begin
            if (w_pad[6*i +: 6] != 6'd0) begin
                w_top = 7'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_top <= '0;
        end else if (w_accept) begin
            r_top <= w_top;
        end
    end

    assign w_last     = (r_cnt == r_top);
    assign w_skip_all = ~|in_data;
`else
    assign w_last     = (r_cnt == c_LAST);
    assign w_skip_all = 1'b0;
`endif

    generate
        if (LUT_LAT == 0) begin : g_lat0
            assign w_due       = w_issue;
            assign w_pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [LUT_LAT-1:0] r_vld;
            logic [LUT_LAT-1:0] w_vld_nxt;

            if (LUT_LAT == 1) begin : g_one
                assign w_vld_nxt = w_issue;
            end else begin : g_multi
                assign w_vld_nxt = {r_vld[LUT_LAT-2:0], w_issue};
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= w_vld_nxt;
                end
            end

            assign w_due       = r_vld[LUT_LAT-1];
            // Empty after this edge means the response due now is the final one.
            assign w_pipe_busy = |w_vld_nxt;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_skip_all ? S_DONE : S_ISSUE;
            S_ISSUE: if (w_last) w_state_nxt = (LUT_LAT > 0) ? S_DRAIN : S_DONE;
            S_DRAIN: if (!w_pipe_busy) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (r_state == S_IDLE);
        lut_req   = rst_n && (r_state == S_ISSUE);
        out_valid = rst_n && (r_state == S_DONE);
        lut_sel   = '0;
        lut_x     = '0;
        out_data  = '0;
        if (lut_req) begin
            lut_sel = r_cnt;
            lut_x   = r_data[5:0];
        end
        if (out_valid) begin
            out_data = r_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= w_pad;
                r_cnt  <= '0;
                r_acc  <= '0;
            end else begin
                if (w_issue) begin
                    r_data <= r_data >> 6;
                    r_cnt  <= r_cnt + 7'd1;
                end
                if (w_due) begin
                    r_acc <= w_acc_nxt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod4051_reduce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod4051_reduce_ctrl
// Brief    : Runs LUT_LAT = 0, 1, 2 instances side by side against a big-integer
//            mod-4051 reference and a behavioural chunk-residue LUT bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod4051_reduce_ctrl;

    localparam int OP_W   = 500;
    localparam int NCH    = (OP_W + 5) / 6;
    localparam int PAD    = NCH * 6;
    localparam int NLAT   = 3;
    localparam int N_RAND = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NLAT-1:0]            rst_n;
    logic [NLAT-1:0]            in_valid;
    logic [NLAT-1:0]            in_ready;
    logic [NLAT-1:0]            lut_req;
    logic [NLAT-1:0]            out_valid;
    logic [NLAT-1:0]            out_ready;
    logic [NLAT-1:0][OP_W-1:0]  in_data;
    logic [NLAT-1:0][6:0]       lut_sel;
    logic [NLAT-1:0][5:0]       lut_x;
    logic [NLAT-1:0][11:0]      out_data;

    int req_cnt [NLAT];
    int sel_err [NLAT];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic string tg(input string name, input int l);
        return $sformatf("%s_lat%0d", name, l);
    endfunction

    // (x * 2^(6*sel)) mod 4051 by repeated doubling.
    function automatic logic [11:0] lut_fn(input logic [6:0] sel, input logic [5:0] x);
        int p = 1;
        for (int i = 0; i < 6 * int'(sel); i++) p = (p * 2) % 4051;
        return 12'((int'(x) * p) % 4051);
    endfunction

    function automatic logic [11:0] ref_mod(input logic [OP_W-1:0] op);
        int r = 0;
        for (int i = OP_W - 1; i >= 0; i--) r = (r * 2 + int'(op[i])) % 4051;
        return 12'(r);
    endfunction

    function automatic int exp_issues(input logic [OP_W-1:0] op);
`ifdef MOD4051_ZERO_SKIP_EN
        int top = -1;
        logic [PAD-1:0] p;
        p = {{(PAD - OP_W){1'b0}}, op};
        for (int i = 0; i < NCH; i++) if (p[6*i +: 6] != 6'd0) top = i;
        return top + 1;
`else
        return NCH;
`endif
    endfunction

    function automatic logic [OP_W-1:0] rand_op();
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[32*i +: 32] = $urandom;
        case ($urandom_range(0, 2))
            0:       t = t;
            1:       t = t >> $urandom_range(440, 511);
            default: t = t >> $urandom_range(0, 439);
        endcase
        return t[OP_W-1:0];
    endfunction

    for (genvar g = 0; g < NLAT; g++) begin : g_dut
        logic [11:0] w_z;
        logic [11:0] w_z_now;
        logic [11:0] r_junk = '0;
        logic [2:0]  r_vp   = '0;
        logic [11:0] r_zp [3];

        mod4051_reduce_ctrl #(.OP_W(OP_W), .LUT_LAT(g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .lut_req   (lut_req[g]),
            .lut_sel   (lut_sel[g]),
            .lut_x     (lut_x[g]),
            .lut_z     (w_z),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );

        always_comb w_z_now = lut_fn(lut_sel[g], lut_x[g]);

        always @(posedge clk) begin
            r_vp    <= {r_vp[1:0], lut_req[g]};
            r_zp[0] <= w_z_now;
            r_zp[1] <= r_zp[0];
            r_zp[2] <= r_zp[1];
        end

        // Off-cycle bus carries random in-range garbage that must be ignored.
        always @(negedge clk) r_junk <= 12'($urandom_range(0, 4050));

        if (g == 0) begin : g_comb
            assign w_z = lut_req[g] ? w_z_now : r_junk;
        end else begin : g_reg
            assign w_z = r_vp[g-1] ? r_zp[g-1] : r_junk;
        end

        always @(negedge clk) begin
            if (rst_n[g]) begin
                if (lut_req[g]) begin
                    if (int'(lut_sel[g]) != req_cnt[g]) sel_err[g]++;
                    req_cnt[g]++;
                end else if (lut_sel[g] != 7'd0 || lut_x[g] != 6'd0) begin
                    sel_err[g]++;
                end
            end
        end
    end

    // Called during the low clock phase; returns 1 ns after the acceptance edge.
    task automatic offer(input int l, input logic [OP_W-1:0] op, output bit ok);
        int cyc = 0;
        in_data[l]  = op;
        in_valid[l] = 1'b1;
        while (!in_ready[l] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        ok = in_ready[l];
        if (!ok) chk(tg("accept_timeout", l), 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid[l] = 1'b0;
        in_data[l]  = rand_op();
        req_cnt[l]  = 0;
    endtask

    task automatic run_op(input int l, input logic [OP_W-1:0] op, input int hold);
        int          cyc = 0;
        int          n_iss;
        int          exp_lat;
        logic [11:0] exp_d;
        logic [11:0] held;
        bit          ok;
        exp_d   = ref_mod(op);
        n_iss   = exp_issues(op);
        exp_lat = (n_iss == 0) ? 1 : n_iss + l + 1;
        offer(l, op, ok);
        if (!ok) return;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid[l] && cyc < 300);
        chk(tg("latency", l), cyc, exp_lat);
        chk(tg("out_data", l), out_data[l], exp_d);
        chk(tg("lut_reqs", l), req_cnt[l], n_iss);
        chk(tg("sel_order", l), sel_err[l], 0);
        held = out_data[l];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk(tg("bp_data_stable", l), out_data[l], held);
            chk(tg("bp_in_ready", l), in_ready[l], 0);
            chk(tg("bp_out_valid", l), out_valid[l], 1);
        end
        out_ready[l] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[l] = 1'b0;
        @(negedge clk);
        chk(tg("ready_after_hs", l), in_ready[l], 1);
        chk(tg("valid_after_hs", l), out_valid[l], 0);
    endtask

    task automatic reset_abort(input int l);
        int cyc  = 0;
        int seen = 0;
        bit ok;
        offer(l, {OP_W{1'b1}}, ok);
        if (!ok) return;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(lut_req[l] && lut_sel[l] == 7'd40) && cyc < 200);
        chk(tg("reach_chunk40", l), lut_sel[l], 40);
        rst_n[l] = 1'b0;
        @(posedge clk);
        #1;
        chk(tg("abort_in_ready", l), in_ready[l], 0);
        chk(tg("abort_lut_req", l), lut_req[l], 0);
        chk(tg("abort_lut_sel", l), lut_sel[l], 0);
        chk(tg("abort_lut_x", l), lut_x[l], 0);
        chk(tg("abort_out_valid", l), out_valid[l], 0);
        chk(tg("abort_out_data", l), out_data[l], 0);
        rst_n[l] = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i == 0) chk(tg("abort_ready_next", l), in_ready[l], 1);
            if (out_valid[l]) seen++;
        end
        chk(tg("no_out_after_abort", l), seen, 0);
        run_op(l, OP_W'(7), 0);
    endtask

    task automatic run_seq(input int l);
        logic [OP_W-1:0] v;
        rst_n[l]     = 1'b0;
        in_valid[l]  = 1'b0;
        out_ready[l] = 1'b0;
        in_data[l]   = '0;
        @(negedge clk);
        chk(tg("rst_in_ready", l), in_ready[l], 0);
        chk(tg("rst_out_valid", l), out_valid[l], 0);
        chk(tg("rst_lut_req", l), lut_req[l], 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n[l] = 1'b1;
        @(negedge clk);
        chk(tg("post_rst_in_ready", l), in_ready[l], 1);
        chk(tg("post_rst_out_valid", l), out_valid[l], 0);
        chk(tg("post_rst_out_data", l), out_data[l], 0);
        chk(tg("post_rst_lut_sel", l), lut_sel[l], 0);
        chk(tg("post_rst_lut_x", l), lut_x[l], 0);

        run_op(l, OP_W'(4050), 0);
        run_op(l, OP_W'(4051), 0);
        run_op(l, OP_W'(8102), 0);
        run_op(l, {OP_W{1'b1}}, 0);
        run_op(l, '0, 0);
        v     = '0;
        v[12] = 1'b1;
        run_op(l, v, 0);
        run_op(l, rand_op(), 10);
        run_op(l, rand_op(), 0);
        reset_abort(l);
        for (int i = 0; i < N_RAND; i++) run_op(l, rand_op(), $urandom_range(0, 3));
    endtask

    initial begin
        fork
            run_seq(0);
            run_seq(1);
            run_seq(2);
        join
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
